// File: rtl/crc_frame_pkg.sv
// Shared types and helpers for the streaming frame CRC generator.
package crc_frame_pkg;

  typedef enum logic {
    PASS   = 1'b0,
    APPEND = 1'b1
  } state_t;

  localparam int MAX_CRC_WIDTH = 64;

  function automatic logic [7:0] flip8(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Reverses the low 'width' bits of v; upper bits return as zero.
  function automatic logic [MAX_CRC_WIDTH-1:0] bitrev(input logic [MAX_CRC_WIDTH-1:0] v,
                                                      input int width);
    logic [MAX_CRC_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_CRC_WIDTH; i++) begin
      if (i < width) r[width-1-i] = v[i];
    end
    return r;
  endfunction

  function automatic int crc_bytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Purpose: advance a CRC register by one data byte, MSB first.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is committed.
module crc_byte_step #(
  parameter int                   CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(32'h04C11DB7)
) (
  input  logic [CRC_WIDTH-1:0] crc_in,
  input  logic [7:0]           data,
  output logic [CRC_WIDTH-1:0] crc_out
);

  always_comb begin
    logic [CRC_WIDTH-1:0] c;
    logic                 msb;
    c   = crc_in;
    msb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      msb = c[CRC_WIDTH-1] ^ data[7-i];
      c   = {c[CRC_WIDTH-2:0], 1'b0};
      if (msb) c = c ^ POLY;
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc_frame_gen.sv
// Purpose: forward a byte stream and compute a per-frame CRC; with CRC_FRAME_APPEND_EN the CRC is appended to the frame.
// Latency: one cycle from input handshake to output valid; 1 byte/cycle sustained.
// Backpressure: output register holds while m_valid_o && !m_ready_i; input ready drops while stalled or appending.
module crc_frame_gen
  import crc_frame_pkg::*;
#(
  parameter int                   CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'(32'h04C11DB7),
  parameter logic [CRC_WIDTH-1:0] INIT      = CRC_WIDTH'(32'hFFFFFFFF),
  parameter bit                   REFLECT   = 1'b1,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = CRC_WIDTH'(32'hFFFFFFFF)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [7:0]           s_data_i,
  input  logic                 s_valid_i,
  input  logic                 s_last_i,
  output logic                 s_ready_o,
  output logic [7:0]           m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic [CRC_WIDTH-1:0] crc_o,
  output logic                 crc_valid_o
);

  logic [CRC_WIDTH-1:0]     crc_q;
  logic [CRC_WIDTH-1:0]     crc_next;
  logic [CRC_WIDTH-1:0]     crc_final;
  logic [MAX_CRC_WIDTH-1:0] crc_next_rev;
  logic [7:0]               step_byte;
  logic                     ready_en;
  logic                     in_pass;
  logic                     s_hs;
  logic                     ld;
  logic [7:0]               ld_data;
  logic                     ld_last;

  assign step_byte = REFLECT ? flip8(s_data_i) : s_data_i;

  crc_byte_step #(
    .CRC_WIDTH (CRC_WIDTH),
    .POLY      (POLY)
  ) u_step (
    .crc_in  (crc_q),
    .data    (step_byte),
    .crc_out (crc_next)
  );

  assign crc_next_rev = bitrev(MAX_CRC_WIDTH'(crc_next), CRC_WIDTH);
  assign crc_final    = (REFLECT ? crc_next_rev[CRC_WIDTH-1:0] : crc_next) ^ XOR_OUT;

  // ready_en keeps s_ready_o low until the first edge after reset release.
  assign s_ready_o = ready_en && in_pass && (!m_valid_o || m_ready_i);
  assign s_hs      = s_valid_i && s_ready_o;

`ifdef CRC_FRAME_APPEND_EN
  localparam int NBYTES = crc_bytes(CRC_WIDTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_t               state_q, state_nxt;
  logic [IDX_W-1:0]     idx_q, idx_nxt;
  logic [7:0]           app_byte;
  logic [CRC_WIDTH-1:0] app_shift;
  int                   byte_sel;
  logic                 idx_last;

  assign in_pass  = (state_q == PASS);
  assign idx_last = (idx_q == IDX_W'(NBYTES - 1));

  always_comb begin
    byte_sel  = REFLECT ? int'(idx_q) : (NBYTES - 1 - int'(idx_q));
    app_shift = crc_o >> (8 * byte_sel);
    app_byte  = app_shift[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PASS;
      idx_q   <= '0;
    end else begin
      state_q <= state_nxt;
      idx_q   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    ld        = 1'b0;
    ld_data   = s_data_i;
    ld_last   = 1'b0;
    if (s_hs) begin
      ld = 1'b1;
      if (s_last_i) begin
        state_nxt = APPEND;
        idx_nxt   = '0;
      end
    end else if (state_q == APPEND && (!m_valid_o || m_ready_i)) begin
      ld      = 1'b1;
      ld_data = app_byte;
      ld_last = idx_last;
      if (idx_last) state_nxt = PASS;
      else          idx_nxt   = idx_q + 1'b1;
    end
  end
`else
  assign in_pass = 1'b1;

  always_comb begin
    ld      = s_hs;
    ld_data = s_data_i;
    ld_last = s_last_i;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en    <= 1'b0;
      crc_q       <= INIT;
      crc_o       <= '0;
      crc_valid_o <= 1'b0;
      m_valid_o   <= 1'b0;
      m_data_o    <= '0;
      m_last_o    <= 1'b0;
    end else begin
      ready_en    <= 1'b1;
      crc_valid_o <= 1'b0;
      if (s_hs) begin
        if (s_last_i) begin
          crc_q       <= INIT;
          crc_o       <= crc_final;
          crc_valid_o <= 1'b1;
        end else begin
          crc_q <= crc_next;
        end
      end
      if (ld) begin
        m_valid_o <= 1'b1;
        m_data_o  <= ld_data;
        m_last_o  <= ld_last;
      end else if (m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule
